// File: rtl/muldiv_pkg.sv
// Shared encodings and constants for the RV32M multiply/divide sequencer.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHU  = 3'd2,
    OP_MULHSU = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } op_e;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_MUL  = 2'd1;
  localparam logic [1:0] ST_DIV  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int          DIV_ITERS  = 32;
  localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN    = 32'h8000_0000;

  // Magnitude of a 32-bit operand; only negated when it is treated as signed.
  function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
    return (is_signed && v[31]) ? -v : v;
  endfunction

endpackage

// File: rtl/muldiv_div_core.sv
// Unsigned restoring divider: one quotient bit per cycle, DIV_ITERS iterations after start.
module muldiv_div_core
  import muldiv_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        clear,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        done,
  output logic [31:0] quotient,
  output logic [31:0] remainder
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [4:0]  cnt_q;
  logic        run_q;
  logic        done_q;
  logic [32:0] shifted;
  logic [32:0] diff;
  logic        fits;

  // NOTE: every signal written in always_comb is assigned on every path, so no latch is inferred.
  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    fits    = shifted[32] || !diff[32];
  end

  // NOTE: sequential state uses non-blocking assignments only, with the async reset as the first branch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (clear) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dvs_q  <= divisor;
      cnt_q  <= '0;
      run_q  <= 1'b1;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (run_q) begin
        if (fits) begin
          rem_q <= diff[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= shifted[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
        // The counter stops at its last value instead of wrapping.
        if (cnt_q == 5'(DIV_ITERS - 1)) begin
          run_q  <= 1'b0;
          done_q <= 1'b1;
        end else begin
          cnt_q <= cnt_q + 5'd1;
        end
      end
    end
  end

  assign done      = done_q;
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/muldiv_seq.sv
// RV32M multiply/divide sequencer: valid/ready request, fixed-latency multiply,
// restoring divide with a 1-cycle special-case path, and a flush that abandons any operation.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] data1,
  input  logic [31:0] data2,
  input  logic [2:0]  select,
  input  logic        flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] result,
  output logic        busy
);

  logic [1:0]  state_q;
  logic [2:0]  op_q;
  logic        sign_a_q;
  logic        sign_b_q;
  logic        fast_q;
  logic [1:0]  mul_cnt_q;
  logic [31:0] result_q;
  logic [63:0] prod_q [MUL_LAT];

  logic        accept;
  logic        div_signed;
  logic        special;
  logic [31:0] special_val;
  logic        a_sgn;
  logic        b_sgn;
  logic signed [63:0] full_prod;

  logic        core_start;
  logic        core_done;
  logic [31:0] core_q;
  logic [31:0] core_r;
  logic [31:0] div_result;
  logic        neg_q;
  logic        neg_r;

  assign req_ready  = (state_q == ST_IDLE) && !flush;
  assign accept     = req_valid && req_ready;
  assign resp_valid = (state_q == ST_DONE);
  assign busy       = (state_q != ST_IDLE);
  assign result     = result_q;

  always_comb begin
    div_signed  = !select[0];
    special     = 1'b0;
    special_val = DIV_ZERO_Q;
    if (data2 == '0) begin
      special     = select[2];
      special_val = select[1] ? data1 : DIV_ZERO_Q;
    end else if (div_signed && data1 == INT_MIN && data2 == '1) begin
      special     = select[2];
      special_val = select[1] ? 32'h0 : INT_MIN;
    end
    a_sgn     = (select != OP_MULHU);
    b_sgn     = (select == OP_MUL) || (select == OP_MULH);
    full_prod = $signed({a_sgn & data1[31], data1}) * $signed({b_sgn & data2[31], data2});
  end

  always_comb begin
    neg_q      = !op_q[0] && (sign_a_q ^ sign_b_q);
    neg_r      = !op_q[0] && sign_a_q;
    div_result = op_q[1] ? (neg_r ? -core_r : core_r)
                         : (neg_q ? -core_q : core_q);
  end

  assign core_start = accept && select[2] && !special;

  muldiv_div_core u_div_core (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (core_start),
    .clear     (flush),
    .dividend  (abs32(data1, div_signed)),
    .divisor   (abs32(data2, div_signed)),
    .done      (core_done),
    .quotient  (core_q),
    .remainder (core_r)
  );

  // NOTE: the product pipeline is pure datapath gated by the FSM, so it carries no reset.
  always_ff @(posedge clk) begin
    if (accept) prod_q[0] <= full_prod;
    for (int i = 1; i < MUL_LAT; i++) prod_q[i] <= prod_q[i-1];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= ST_IDLE;
      op_q      <= OP_MUL;
      sign_a_q  <= 1'b0;
      sign_b_q  <= 1'b0;
      fast_q    <= 1'b0;
      mul_cnt_q <= '0;
      result_q  <= '0;
    end else if (flush) begin
      state_q <= ST_IDLE;
      fast_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) begin
          op_q      <= select;
          sign_a_q  <= data1[31];
          sign_b_q  <= data2[31];
          mul_cnt_q <= '0;
          if (!select[2]) begin
            state_q <= ST_MUL;
          end else begin
            // Special cases park in DIV for one cycle with the answer already in place.
            state_q <= ST_DIV;
            fast_q  <= special;
            if (special) result_q <= special_val;
          end
        end
        ST_MUL: begin
          if (mul_cnt_q == 2'(MUL_LAT - 1)) begin
            state_q  <= ST_DONE;
            result_q <= (op_q == OP_MUL) ? prod_q[MUL_LAT-1][31:0] : prod_q[MUL_LAT-1][63:32];
          end else begin
            mul_cnt_q <= mul_cnt_q + 2'd1;
          end
        end
        ST_DIV: begin
          if (fast_q) begin
            state_q <= ST_DONE;
            fast_q  <= 1'b0;
          end else if (core_done) begin
            state_q  <= ST_DONE;
            result_q <= div_result;
          end
        end
        ST_DONE: if (resp_ready) state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq against a plain-arithmetic RV32M reference model.
module tb_muldiv_seq;

  localparam int MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        req_valid = 1'b0;
  logic        flush = 1'b0;
  logic        resp_ready = 1'b0;
  logic [31:0] data1 = '0;
  logic [31:0] data2 = '0;
  logic [2:0]  select = '0;
  logic        req_ready;
  logic        resp_valid;
  logic        busy;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;

  muldiv_seq #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .data1      (data1),
    .data2      (data2),
    .select     (select),
    .flush      (flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .result     (result),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                             input logic [2:0] op);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic        ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ua  = longint'({32'b0, a});
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (op)
      3'd0: begin p = 64'(sa * sb); return p[31:0]; end
      3'd1: begin p = 64'(sa * sb); return p[63:32]; end
      3'd2: begin p = 64'(ua * ub); return p[63:32]; end
      3'd3: begin p = 64'(sa * ub); return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(sa % sb);
      default: return (b == 0) ? a : 32'(ua % ub);
    endcase
  endfunction

  function automatic int ref_latency(input logic [31:0] a, input logic [31:0] b,
                                     input logic [2:0] op);
    if (op < 3'd4) return MUL_LAT;
    if (b == 0) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Wait for RESP_VALID after an acceptance edge; lat counts edges after E0, -1 on timeout.
  task automatic wait_resp(output int lat);
    lat = 0;
    while (resp_valid !== 1'b1 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    if (resp_valid !== 1'b1) lat = -1;
  endtask

  // Issue one request, wait for its response, then consume it.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                       output logic [31:0] res, output int lat);
    @(negedge clk);
    data1 = a; data2 = b; select = op; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    data1 = $urandom; data2 = $urandom; select = 3'($urandom);
    wait_resp(lat);
    res = result;
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic check_op(input string name, input logic [31:0] a, input logic [31:0] b,
                          input logic [2:0] op, input logic [31:0] exp_res, input int exp_lat);
    logic [31:0] res;
    int lat;
    do_op(a, b, op, res, lat);
    vectors++;
    if (res !== exp_res || lat != exp_lat) begin
      miscompares++;
      $display("FAIL %s sel=%0d a=%h b=%h: result %h latency %0d, expected %h latency %0d",
               name, op, a, b, res, lat, exp_res, exp_lat);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    vectors++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state: resp_valid=%b busy=%b result=%h, expected 0 0 00000000",
               resp_valid, busy, result);
    end
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    vectors++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_ready: req_ready=%b busy=%b, expected 1 0", req_ready, busy);
    end
    flush = 1'b1; #1;
    vectors++;
    if (req_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL ready_under_flush: req_ready=%b, expected 0", req_ready);
    end
    flush = 1'b0;
  endtask

  task automatic test_mul();
    check_op("mul_plan", 32'hFFFF_FFFF, 32'h2, 3'd0, 32'hFFFF_FFFE, MUL_LAT);
    check_op("mul_plan", 32'hFFFF_FFFF, 32'h2, 3'd1, 32'hFFFF_FFFF, MUL_LAT);
    check_op("mul_plan", 32'hFFFF_FFFF, 32'h2, 3'd2, 32'h0000_0001, MUL_LAT);
    check_op("mul_plan", 32'hFFFF_FFFF, 32'h2, 3'd3, 32'hFFFF_FFFF, MUL_LAT);
  endtask

  task automatic test_div();
    check_op("div_plan", 32'hFFFF_FFF9, 32'h2, 3'd4, 32'hFFFF_FFFD, 33);
    check_op("div_plan", 32'hFFFF_FFF9, 32'h2, 3'd5, 32'h7FFF_FFFC, 33);
    check_op("div_plan", 32'hFFFF_FFF9, 32'h2, 3'd6, 32'hFFFF_FFFF, 33);
    check_op("div_plan", 32'hFFFF_FFF9, 32'h2, 3'd7, 32'h0000_0001, 33);
  endtask

  task automatic test_div_zero();
    check_op("div_zero", 32'h0000_1234, 32'h0, 3'd4, 32'hFFFF_FFFF, 1);
    check_op("div_zero", 32'h0000_1234, 32'h0, 3'd5, 32'hFFFF_FFFF, 1);
    check_op("div_zero", 32'h0000_1234, 32'h0, 3'd6, 32'h0000_1234, 1);
    check_op("div_zero", 32'h0000_1234, 32'h0, 3'd7, 32'h0000_1234, 1);
  endtask

  task automatic test_overflow();
    check_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 3'd4, 32'h8000_0000, 1);
    check_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 3'd6, 32'h0000_0000, 1);
    check_op("overflow", 32'h8000_0000, 32'hFFFF_FFFF, 3'd5, 32'h0000_0000, 33);
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    int lat;
    @(negedge clk);
    data1 = 32'd100; data2 = 32'd7; select = 3'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    held = result;
    vectors++;
    if (held !== 32'd14 || lat != 33) begin
      miscompares++;
      $display("FAIL bp_first: result %h latency %0d, expected 0000000e latency 33", held, lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      req_valid = (i == 2);
      data1 = 32'd9; data2 = 32'd9; select = 3'd0;
      vectors++;
      if (resp_valid !== 1'b1 || result !== held || req_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL bp_hold cycle %0d: resp_valid=%b result=%h req_ready=%b, expected 1 %h 0",
                 i, resp_valid, result, req_ready, held);
      end
    end
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; data1 = 32'd3; data2 = 32'd5; select = 3'd0;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    vectors++;
    if (resp_valid !== 1'b0 || busy !== 1'b0 || req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: resp_valid=%b busy=%b req_ready=%b, expected 0 0 1",
               resp_valid, busy, req_ready);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_next_accept: busy=%b, expected 1", busy);
    end
    wait_resp(lat);
    vectors++;
    if (result !== 32'h0000_000F || lat != MUL_LAT) begin
      miscompares++;
      $display("FAIL bp_next_result: result %h latency %0d, expected 0000000f latency %0d",
               result, lat, MUL_LAT);
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
  endtask

  task automatic test_flush();
    logic seen;
    int lat;
    @(negedge clk);
    data1 = 32'd1000; data2 = 32'd3; select = 3'd5; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) @(posedge clk);
    @(negedge clk); flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    vectors++;
    if (busy !== 1'b0 || resp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_div: busy=%b resp_valid=%b, expected 0 0", busy, resp_valid);
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_no_resp: response seen=%b, expected 0", seen);
    end
    @(negedge clk);
    flush = 1'b1; req_valid = 1'b1; data1 = 32'd3; data2 = 32'd5; select = 3'd0;
    @(posedge clk); #1;
    flush = 1'b0; req_valid = 1'b0;
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL flush_blocks_req: busy=%b, expected 0", busy);
    end
    check_op("after_flush", 32'd3, 32'd5, 3'd0, 32'h0000_000F, MUL_LAT);
    // FLUSH together with RESP_READY in DONE: one response only.
    @(negedge clk);
    data1 = 32'd6; data2 = 32'd7; select = 3'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    wait_resp(lat);
    @(negedge clk); flush = 1'b1; resp_ready = 1'b1;
    @(posedge clk); #1; flush = 1'b0; resp_ready = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (resp_valid !== 1'b0 || busy !== 1'b0) seen = 1'b1;
    end
    vectors++;
    if (seen !== 1'b0 || lat != MUL_LAT) begin
      miscompares++;
      $display("FAIL flush_and_ready: extra activity=%b latency %0d, expected 0 latency %0d",
               seen, lat, MUL_LAT);
    end
  endtask

  task automatic test_reset_mid_div();
    @(negedge clk);
    data1 = 32'd5000; data2 = 32'd9; select = 3'd4; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 reset_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 1'b0 || resp_valid !== 1'b0 || result !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_mid_div: busy=%b resp_valid=%b result=%h, expected 0 0 00000000",
               busy, resp_valid, result);
    end
    @(negedge clk); reset_n = 1'b1;
    check_op("after_reset", 32'd100, 32'd7, 3'd5, 32'd14, 33);
  endtask

  task automatic test_random();
    logic [31:0] a, b;
    logic [2:0]  op;
    for (int n = 0; n < 60; n++) begin
      op = 3'($urandom);
      a  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'h0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: b = $urandom;
      endcase
      check_op("random", a, b, op, ref_result(a, b, op), ref_latency(a, b, op));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_mul();
    test_div();
    test_div_zero();
    test_overflow();
    test_backpressure();
    test_flush();
    test_reset_mid_div();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
